// File: rtl/hive_lifo_ring_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hive_lifo_ring_pkg
// Description : Shared types and helpers for the multi-thread LIFO bank.
// Revision    : 1.0 - initial release
// ============================================================================
package hive_lifo_ring_pkg;

  // Overflow/underflow policy of a stack.
  typedef enum logic {
    MODE_PROTECT = 1'b0,  // block the operation on full/empty
    MODE_RING    = 1'b1   // wrap the pointer, overwrite the oldest entry
  } lifo_mode_t;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hive_lifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : hive_lifo_ptr
// Description : Pointer / fill-count unit of one stack. Applies push, pop and
//               clear, and reports full state and overflow/underflow errors.
// Revision    : 1.0 - initial release
// ============================================================================
module hive_lifo_ptr
  import hive_lifo_ring_pkg::*;
#(
  parameter  int         DEPTH = 32,
  parameter  lifo_mode_t MODE  = MODE_PROTECT,
  localparam int         PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [PTR_W-1:0] ptr_o,
  output logic [PTR_W:0]   cnt_o,
  output logic             full_o,
  output logic             psh_er_o,
  output logic             pop_er_o
);

  localparam logic [PTR_W:0] c_full = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W:0]   r_cnt;
  logic [PTR_W:0]   w_cnt_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_psh_er;
  logic             w_pop_er;

  assign w_full  = (r_cnt == c_full);
  assign w_empty = (r_cnt == '0);

  // Next pointer/count; clear wins, a simultaneous push+pop is a net no-op.
  always_comb begin
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_cnt;
    w_psh_er  = 1'b0;
    w_pop_er  = 1'b0;
    if (clear_i) begin
      w_ptr_nxt = '0;
      w_cnt_nxt = '0;
    end else if (push_i && pop_i) begin
      w_ptr_nxt = r_ptr;
      w_cnt_nxt = r_cnt;
    end else if (push_i) begin
      if (w_full) begin
        w_psh_er = 1'b1;
        if (MODE == MODE_RING) begin
          w_ptr_nxt = r_ptr + PTR_W'(1);
        end
      end else begin
        w_ptr_nxt = r_ptr + PTR_W'(1);
        w_cnt_nxt = r_cnt + (PTR_W + 1)'(1);
      end
    end else if (pop_i) begin
      if (w_empty) begin
        w_pop_er = 1'b1;
        if (MODE == MODE_RING) begin
          w_ptr_nxt = r_ptr - PTR_W'(1);
        end
      end else begin
        w_ptr_nxt = r_ptr - PTR_W'(1);
        w_cnt_nxt = r_cnt - (PTR_W + 1)'(1);
      end
    end
  end

  // Pointer/count state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign ptr_o    = r_ptr;
  assign cnt_o    = r_cnt;
  assign full_o   = w_full;
  assign psh_er_o = w_psh_er;
  assign pop_er_o = w_pop_er;

endmodule
`default_nettype wire

// File: rtl/hive_lifo_ring.sv
`default_nettype none
// ============================================================================
// Module      : hive_lifo_ring
// Description : Multi-thread LIFO bank (THREADS x STACKS stacks of DEPTH
//               words) with two read ports for the A/B operands and one
//               push port for the result. Reads have two cycles of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module hive_lifo_ring
  import hive_lifo_ring_pkg::*;
#(
  parameter  int THREADS = 8,
  parameter  int STACKS  = 8,
  parameter  int DEPTH   = 32,
  parameter  int DATA_W  = 36,
  parameter  int PROTECT = 1,
  localparam int THD_W   = idx_width(THREADS),
  localparam int STK_W   = $clog2(STACKS),
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [THD_W-1:0]  rd_id_i,
  input  logic              clt_i,
  input  logic [STK_W-1:0]  a_sel_i,
  input  logic [STK_W-1:0]  b_sel_i,
  input  logic [STACKS-1:0] pop_i,
  input  logic [THD_W-1:0]  psh_id_i,
  input  logic              psh_i,
  input  logic [STK_W-1:0]  psh_sel_i,
  input  logic [DATA_W-1:0] psh_data_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [PTR_W:0]    a_lvl_o,
  output logic [THREADS-1:0] pop_er_o,
  output logic [THREADS-1:0] psh_er_o
);

  localparam int         c_nstk  = THREADS * STACKS;
  localparam int         c_words = c_nstk * DEPTH;
  localparam int         c_sw    = THD_W + STK_W;
  localparam int         c_aw    = THD_W + STK_W + PTR_W;
  localparam lifo_mode_t c_mode  = (PROTECT != 0) ? MODE_PROTECT : MODE_RING;

  // Per-stack control and status, indexed by {thread, stack}.
  logic [c_nstk-1:0] w_u_push;
  logic [c_nstk-1:0] w_u_pop;
  logic [c_nstk-1:0] w_u_clear;
  logic [c_nstk-1:0] w_full;
  logic [c_nstk-1:0] w_u_psh_er;
  logic [c_nstk-1:0] w_u_pop_er;
  logic [PTR_W-1:0]  w_ptr [c_nstk];
  logic [PTR_W:0]    w_cnt [c_nstk];

  logic [THREADS-1:0] w_psh_er_vec;
  logic [THREADS-1:0] w_pop_er_vec;

  // Storage is deliberately left without reset.
  logic [DATA_W-1:0] r_mem [c_words];

  generate
    for (genvar t = 0; t < THREADS; t++) begin : g_thd
      for (genvar s = 0; s < STACKS; s++) begin : g_stk
        localparam int c_idx = t * STACKS + s;

        assign w_u_clear[c_idx] = clt_i && (rd_id_i == THD_W'(t));
        assign w_u_pop[c_idx]   = (rd_id_i == THD_W'(t)) && pop_i[s];
        assign w_u_push[c_idx]  = psh_i && (psh_id_i == THD_W'(t)) &&
                                  (psh_sel_i == STK_W'(s));

        hive_lifo_ptr #(
          .DEPTH (DEPTH),
          .MODE  (c_mode)
        ) u_ptr (
          .clk_i    (clk_i),
          .rst_n_i  (rst_n_i),
          .push_i   (w_u_push[c_idx]),
          .pop_i    (w_u_pop[c_idx]),
          .clear_i  (w_u_clear[c_idx]),
          .ptr_o    (w_ptr[c_idx]),
          .cnt_o    (w_cnt[c_idx]),
          .full_o   (w_full[c_idx]),
          .psh_er_o (w_u_psh_er[c_idx]),
          .pop_er_o (w_u_pop_er[c_idx])
        );
      end

      // A thread's error bit is the OR over all of its stacks.
      assign w_psh_er_vec[t] = |w_u_psh_er[t*STACKS +: STACKS];
      assign w_pop_er_vec[t] = |w_u_pop_er[t*STACKS +: STACKS];
    end
  endgenerate

  // Write port: target stack state and the write address it implies.
  logic [c_sw-1:0]  w_wr_idx;
  logic [PTR_W-1:0] w_wr_ptr;
  logic             w_wr_same_pop;
  logic             w_wr_cleared;
  logic             w_wr_en;
  logic [c_aw-1:0]  w_wr_addr;

  assign w_wr_idx      = {psh_id_i, psh_sel_i};
  assign w_wr_same_pop = (rd_id_i == psh_id_i) && pop_i[psh_sel_i];
  assign w_wr_cleared  = clt_i && (rd_id_i == psh_id_i);

  // Push+pop on one stack replaces the top in place (write at ptr-1);
  // a full protected stack and a push into a thread being cleared are dropped.
  always_comb begin
    w_wr_ptr  = w_ptr[w_wr_idx];
    w_wr_en   = psh_i && !w_wr_cleared &&
                (w_wr_same_pop || (c_mode == MODE_RING) || !w_full[w_wr_idx]);
    w_wr_addr = {psh_id_i, psh_sel_i,
                 w_wr_same_pop ? (w_wr_ptr - PTR_W'(1)) : w_wr_ptr};
  end

  // Storage write port.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= psh_data_i;
    end
  end

  // Read stage 1: top-of-stack addresses and level from pre-update state.
  logic [c_sw-1:0]  w_a_idx;
  logic [c_sw-1:0]  w_b_idx;
  logic [c_aw-1:0]  r_a_addr;
  logic [c_aw-1:0]  r_b_addr;
  logic [PTR_W:0]   r_a_lvl;
  logic             r_rd_vld;

  assign w_a_idx = {rd_id_i, a_sel_i};
  assign w_b_idx = {rd_id_i, b_sel_i};

  // Register read addresses; r_rd_vld suppresses the first read after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_a_addr <= '0;
      r_b_addr <= '0;
      r_a_lvl  <= '0;
      r_rd_vld <= 1'b0;
    end else begin
      r_a_addr <= {rd_id_i, a_sel_i, w_ptr[w_a_idx] - PTR_W'(1)};
      r_b_addr <= {rd_id_i, b_sel_i, w_ptr[w_b_idx] - PTR_W'(1)};
      r_a_lvl  <= w_cnt[w_a_idx];
      r_rd_vld <= 1'b1;
    end
  end

  // Read stage 2 and error pulses: output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_o      <= '0;
      b_o      <= '0;
      a_lvl_o  <= '0;
      psh_er_o <= '0;
      pop_er_o <= '0;
    end else begin
      a_o      <= r_rd_vld ? r_mem[r_a_addr] : '0;
      b_o      <= r_rd_vld ? r_mem[r_b_addr] : '0;
      a_lvl_o  <= r_rd_vld ? r_a_lvl : '0;
      psh_er_o <= w_psh_er_vec;
      pop_er_o <= w_pop_er_vec;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hive_lifo_ring.sv
`default_nettype none
// ============================================================================
// Module      : tb_hive_lifo_ring
// Description : Scoreboard bench for hive_lifo_ring. One protected and one
//               ring instance (DEPTH=4) share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hive_lifo_ring;

  localparam int THREADS = 8;
  localparam int STACKS  = 8;
  localparam int DEPTH   = 4;
  localparam int DATA_W  = 36;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        rd_id, psh_id, a_sel, b_sel, psh_sel;
  logic              clt, psh;
  logic [7:0]        pop;
  logic [DATA_W-1:0] psh_data;

  logic [DATA_W-1:0] a_p, b_p, a_r, b_r;
  logic [2:0]        lvl_p, lvl_r;
  logic [7:0]        pe_p, pe_r, se_p, se_r;

  hive_lifo_ring #(
    .THREADS(THREADS), .STACKS(STACKS), .DEPTH(DEPTH), .DATA_W(DATA_W), .PROTECT(1)
  ) u_prot (
    .clk_i(clk), .rst_n_i(rst_n), .rd_id_i(rd_id), .clt_i(clt),
    .a_sel_i(a_sel), .b_sel_i(b_sel), .pop_i(pop), .psh_id_i(psh_id),
    .psh_i(psh), .psh_sel_i(psh_sel), .psh_data_i(psh_data),
    .a_o(a_p), .b_o(b_p), .a_lvl_o(lvl_p), .pop_er_o(pe_p), .psh_er_o(se_p)
  );

  hive_lifo_ring #(
    .THREADS(THREADS), .STACKS(STACKS), .DEPTH(DEPTH), .DATA_W(DATA_W), .PROTECT(0)
  ) u_ring (
    .clk_i(clk), .rst_n_i(rst_n), .rd_id_i(rd_id), .clt_i(clt),
    .a_sel_i(a_sel), .b_sel_i(b_sel), .pop_i(pop), .psh_id_i(psh_id),
    .psh_i(psh), .psh_sel_i(psh_sel), .psh_data_i(psh_data),
    .a_o(a_r), .b_o(b_r), .a_lvl_o(lvl_r), .pop_er_o(pe_r), .psh_er_o(se_r)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 a_o, 1 b_o, 2 a_lvl_o, 3 psh_er_o, 4 pop_er_o; dut: 0 prot, 1 ring
  typedef struct {
    int          due;
    int          dut;
    int          kind;
    logic [35:0] val;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  e_psh[2];
  logic [7:0]  e_pop[2];
  logic [35:0] act;

  function automatic logic [35:0] actual(input int dut, input int kind);
    case (kind)
      0:       return (dut != 0) ? a_r : a_p;
      1:       return (dut != 0) ? b_r : b_p;
      2:       return {33'b0, ((dut != 0) ? lvl_r : lvl_p)};
      3:       return {28'b0, ((dut != 0) ? se_r : se_p)};
      default: return {28'b0, ((dut != 0) ? pe_r : pe_p)};
    endcase
  endfunction

  // Monitor: compare every expectation that falls due on this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        checks++;
        act = actual(sb[i].dut, sb[i].kind);
        if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s dut%0d cyc %0d: got %h want %h",
                   sb[i].tag, sb[i].dut, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s dut%0d: expectation for cyc %0d never checked",
                 sb[i].tag, sb[i].dut, sb[i].due);
        sb.delete(i);
      end
    end
  end

  task automatic exp_at(input int lat, input string tag, input int dut,
                        input int kind, input logic [35:0] v);
    sb.push_back('{cyc + lat, dut, kind, v, tag});
  endtask

  task automatic exp_a(input string tag, input logic [35:0] vp, input logic [35:0] vr);
    exp_at(2, tag, 0, 0, vp);
    exp_at(2, tag, 1, 0, vr);
  endtask

  task automatic exp_b(input string tag, input logic [35:0] vp, input logic [35:0] vr);
    exp_at(2, tag, 0, 1, vp);
    exp_at(2, tag, 1, 1, vr);
  endtask

  task automatic exp_lvl(input string tag, input int lp, input int lr);
    exp_at(2, tag, 0, 2, 36'(lp));
    exp_at(2, tag, 1, 2, 36'(lr));
  endtask

  task automatic idle();
    rd_id = 0; a_sel = 0; b_sel = 0; pop = 0; clt = 0;
    psh = 0; psh_id = 0; psh_sel = 0; psh_data = '0;
  endtask

  // Close the cycle: expect this cycle's error pulses, then advance.
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      exp_at(1, "psh_er", d, 3, {28'b0, e_psh[d]});
      exp_at(1, "pop_er", d, 4, {28'b0, e_pop[d]});
      e_psh[d] = '0;
      e_pop[d] = '0;
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_push(input int t, input int s, input logic [35:0] d);
    psh = 1'b1; psh_id = 3'(t); psh_sel = 3'(s); psh_data = d;
    tick();
  endtask

  task automatic set_rd(input int t, input int sa, input int sb_sel);
    rd_id = 3'(t); a_sel = 3'(sa); b_sel = 3'(sb_sel);
  endtask

  task automatic exp_reset_now();
    for (int d = 0; d < 2; d++) begin
      exp_at(0, "rst_a", d, 0, '0);
      exp_at(0, "rst_b", d, 1, '0);
      exp_at(0, "rst_lvl", d, 2, '0);
    end
  endtask

  initial begin
    idle();
    e_psh[0] = '0; e_psh[1] = '0; e_pop[0] = '0; e_pop[1] = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_reset_now();
    tick();
    rst_n = 1'b1;
    tick();

    // Thread 2, stack 1: push three values, read, pop, read.
    do_push(2, 1, 36'h11);
    do_push(2, 1, 36'h22);
    do_push(2, 1, 36'h33);
    set_rd(2, 1, 1);
    exp_a("t2_top", 36'h33, 36'h33); exp_b("t2_topb", 36'h33, 36'h33);
    exp_lvl("t2_lvl3", 3, 3);
    tick();
    set_rd(2, 1, 1); pop = 8'h02;
    exp_a("t2_prepop", 36'h33, 36'h33); exp_lvl("t2_prepop_lvl", 3, 3);
    tick();
    set_rd(2, 1, 1);
    exp_a("t2_afterpop", 36'h22, 36'h22); exp_lvl("t2_lvl2", 2, 2);
    tick();

    // Thread 4, stack 0: overflow then underflow, protected vs ring.
    for (int v = 1; v <= 5; v++) begin
      if (v == 5) begin
        e_psh[0] = 8'h10; e_psh[1] = 8'h10;
      end
      do_push(4, 0, 36'(v));
    end
    for (int i = 0; i < 4; i++) begin
      set_rd(4, 0, 0); pop = 8'h01;
      exp_a("ovf_pop_top", 36'(4 - i), 36'(5 - i));
      exp_lvl("ovf_pop_lvl", 4 - i, 4 - i);
      tick();
    end
    set_rd(4, 0, 0); pop = 8'h01;
    e_pop[0] = 8'h10; e_pop[1] = 8'h10;
    exp_lvl("udf_lvl", 0, 0);
    tick();
    set_rd(4, 0, 0);
    exp_lvl("udf_lvl_after", 0, 0);
    tick();

    // Thread 3: clear overrides pops and a same-thread push.
    do_push(3, 0, 36'h31);
    do_push(3, 0, 36'h32);
    do_push(3, 4, 36'h41);
    do_push(3, 4, 36'h42);
    set_rd(3, 0, 4);
    exp_a("t3_s0", 36'h32, 36'h32); exp_b("t3_s4", 36'h42, 36'h42);
    exp_lvl("t3_lvl", 2, 2);
    tick();
    set_rd(3, 0, 4); clt = 1'b1; pop = 8'h11;
    psh = 1'b1; psh_id = 3'd3; psh_sel = 3'd0; psh_data = 36'h99;
    exp_lvl("clt_prelvl", 2, 2);
    tick();
    set_rd(3, 0, 0);
    exp_lvl("clt_s0", 0, 0);
    tick();
    set_rd(3, 4, 4);
    exp_lvl("clt_s4", 0, 0);
    tick();

    // Thread 1, stack 5: push and pop in one cycle replaces the top.
    do_push(1, 5, 36'hA);
    do_push(1, 5, 36'hB);
    rd_id = 3'd1; pop = 8'h20;
    psh = 1'b1; psh_id = 3'd1; psh_sel = 3'd5; psh_data = 36'hC;
    tick();
    set_rd(1, 5, 5);
    exp_a("pp_top", 36'hC, 36'hC); exp_b("pp_topb", 36'hC, 36'hC);
    exp_lvl("pp_lvl", 2, 2);
    tick();
    set_rd(1, 5, 5); pop = 8'h20;
    exp_a("pp_prepop", 36'hC, 36'hC);
    tick();
    set_rd(1, 5, 5);
    exp_a("pp_below", 36'hA, 36'hA); exp_lvl("pp_lvl1", 1, 1);
    tick();

    // Reset with a read in flight.
    do_push(6, 2, 36'h77);
    do_push(6, 2, 36'h78);
    set_rd(6, 2, 2);
    tick();
    rst_n = 1'b0;
    #1;
    exp_reset_now();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    set_rd(6, 2, 2);
    exp_lvl("post_rst_t6", 0, 0);
    tick();
    set_rd(2, 1, 1);
    exp_lvl("post_rst_t2", 0, 0);
    tick();
    tick();

    // Drain remaining expectations with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d pending expectations, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
